// File: rtl/cs_m_layer.sv
// CS-Cipher M-layer stage: applies the byte-pair mixing function M to a 64-bit word,
// routing all eight lookups through a single shared P permutation, one byte per cycle.
module cs_m_layer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [63:0] work_reg;
    logic [63:0] result_reg;

    logic [7:0]  xl_arr [4];
    logic [7:0]  xr_arr [4];
    logic [7:0]  sel_xl, sel_xr;
    logic [7:0]  p_in, p_out;
    logic [2:0]  byte_idx;

    function automatic logic [3:0] f_nib(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hF;  4'h1: y = 4'hD;  4'h2: y = 4'hB;  4'h3: y = 4'hB;
            4'h4: y = 4'h7;  4'h5: y = 4'h5;  4'h6: y = 4'h7;  4'h7: y = 4'h7;
            4'h8: y = 4'hE;  4'h9: y = 4'hD;  4'hA: y = 4'hA;  4'hB: y = 4'hB;
            4'hC: y = 4'hE;  4'hD: y = 4'hD;  4'hE: y = 4'hE;  default: y = 4'hF;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] g_nib(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h6;  4'h2: y = 4'h0;  4'h3: y = 4'h2;
            4'h4: y = 4'hB;  4'h5: y = 4'hE;  4'h6: y = 4'h1;  4'h7: y = 4'h8;
            4'h8: y = 4'hD;  4'h9: y = 4'h4;  4'hA: y = 4'h5;  4'hB: y = 4'h3;
            4'hC: y = 4'hF;  4'hD: y = 4'hC;  4'hE: y = 4'h7;  default: y = 4'h9;
        endcase
        return y;
    endfunction

    // P is a three-round nibble Feistel built from f and g
    function automatic logic [7:0] p_perm(input logic [7:0] x);
        logic [3:0] t, u, v;
        t = x[7:4] ^ f_nib(x[3:0]);
        u = x[3:0] ^ g_nib(t);
        v = t ^ f_nib(u);
        return {v, u};
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pair
            assign xl_arr[gi] = work_reg[16*gi+8 +: 8];
            assign xr_arr[gi] = work_reg[16*gi   +: 8];
        end
    endgenerate

    // Even steps produce yl (upper byte of the pair), odd steps produce yr
    always_comb begin
        sel_xl   = xl_arr[cnt_reg[2:1]];
        sel_xr   = xr_arr[cnt_reg[2:1]];
        p_in     = cnt_reg[0] ? (rotl1(sel_xl) ^ sel_xr)
                              : (((rotl1(sel_xl) & 8'h55) ^ sel_xl) ^ sel_xr);
        p_out    = p_perm(p_in);
        byte_idx = {cnt_reg[2:1], ~cnt_reg[0]};
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: if (in_valid) begin
                state_next = CALC;
                cnt_next   = 3'd0;
            end
            CALC: begin
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            work_reg   <= 64'h0;
            result_reg <= 64'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && in_valid)
                work_reg <= in_data;
            if (state_reg == CALC) begin
                for (int i = 0; i < 8; i++) begin
                    if (byte_idx == 3'(i))
                        result_reg[8*i +: 8] <= p_out;
                end
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = result_reg;

endmodule

// File: tb/tb_cs_m_layer.sv
// Self-checking bench for cs_m_layer: directed vectors, random words against a
// table-driven M-layer model, backpressure, back-to-back flow and mid-run reset.
module tb_cs_m_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] W0 = 64'h0;
    localparam logic [63:0] R0 = 64'h2929_2929_2929_2929;
    localparam logic [63:0] W1 = 64'h0100_00FF_8000_0000;
    localparam logic [63:0] R1 = 64'h0D61_5555_AF0D_2929;

    logic [3:0] f_tab [0:15] = '{4'hF,4'hD,4'hB,4'hB,4'h7,4'h5,4'h7,4'h7,
                                 4'hE,4'hD,4'hA,4'hB,4'hE,4'hD,4'hE,4'hF};
    logic [3:0] g_tab [0:15] = '{4'hA,4'h6,4'h0,4'h2,4'hB,4'hE,4'h1,4'h8,
                                 4'hD,4'h4,4'h5,4'h3,4'hF,4'hC,4'h7,4'h9};

    always #5 clk = ~clk;

    cs_m_layer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    function automatic logic [7:0] model_p(input logic [7:0] x);
        logic [3:0] t, u, v;
        t = x[7:4] ^ f_tab[x[3:0]];
        u = x[3:0] ^ g_tab[t];
        v = t ^ f_tab[u];
        return {v, u};
    endfunction

    function automatic logic [63:0] model_m(input logic [63:0] w);
        logic [63:0] r;
        logic [7:0]  xl, xr, rl;
        r = 64'h0;
        for (int p = 0; p < 4; p++) begin
            xl = w[16*p+8 +: 8];
            xr = w[16*p +: 8];
            rl = {xl[6:0], xl[7]};
            r[16*p+8 +: 8] = model_p(((rl & 8'h55) ^ xl) ^ xr);
            r[16*p   +: 8] = model_p(rl ^ xr);
        end
        return r;
    endfunction

    // Pushes one word from IDLE and returns the result and accept-to-valid latency (-1 on timeout)
    task automatic do_word(input logic [63:0] d, input bit toggle,
                           output logic [63:0] r, output int lat);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        r   = 64'h0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) begin
                lat = c - 1;
                break;
            end
            if (toggle) in_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        if (lat < 0 && out_valid) lat = 40;
        r = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: ready/valid/busy=%b out_data=%h, expected 100 and 0",
                     {in_ready, out_valid, busy}, out_data);
        end
        // reset wins over an incoming word
        in_valid = 1'b1; in_data = W1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_valid: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
        end
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_no_capture: busy=%b out_data=%h, expected 0 0", busy, out_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_vectors;
        logic [63:0] r;
        int lat;
        do_word(W0, 1'b0, r, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL latency_w0: got %0d, expected 8", lat);
        end
        checks++;
        if (r !== R0) begin
            errors++;
            $display("FAIL result_w0: got %h, expected %h", r, R0);
        end
        $display("word %h -> %h lat=%0d", W0, r, lat);
        do_word(W1, 1'b0, r, lat);
        checks++;
        if (r !== R1 || lat !== 8) begin
            errors++;
            $display("FAIL result_w1: got %h lat=%0d, expected %h lat=8", r, lat, R1);
        end
        $display("word %h -> %h lat=%0d", W1, r, lat);
    endtask

    task automatic test_random(input bit toggle);
        logic [63:0] d, r, e;
        int lat;
        for (int n = 0; n < 8; n++) begin
            d = {$urandom, $urandom};
            e = model_m(d);
            do_word(d, toggle, r, lat);
            checks++;
            if (r !== e || lat !== 8) begin
                errors++;
                $display("FAIL random_word(toggle=%0d): in=%h got %h lat=%0d, expected %h lat=8",
                         toggle, d, r, lat, e);
            end else
                $display("word %h -> %h toggle=%0d", d, r, toggle);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        in_data = W1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b1 || out_data !== R1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
            in_valid = (c == 5);
            in_data  = W0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d bad cycles, expected 0 (out_data=%h)", bad, out_data);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== R1) begin
            errors++;
            $display("FAIL backpressure_end: valid=%b data=%h, expected 1 %h", out_valid, out_data, R1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b ready=%b busy=%b, expected 0 1 0",
                     out_valid, in_ready, busy);
        end
        $display("backpressure word %h -> %h released", W1, R1);
    endtask

    task automatic test_back_to_back;
        int acc_cyc [$];
        logic [63:0] res [$];
        bit acc, fire;
        in_data = W0; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 60 && res.size() < 2; c++) begin
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (acc) acc_cyc.push_back(c);
            if (fire) res.push_back(out_data);
            @(posedge clk); #1;
            if (acc) in_data = W1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 10) begin
            errors++;
            $display("FAIL b2b_interval: accepts=%0d gap=%0d, expected gap 10", acc_cyc.size(),
                     acc_cyc.size() >= 2 ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        checks++;
        if (res.size() != 2 || res[0] !== R0 || res[1] !== R1) begin
            errors++;
            $display("FAIL b2b_results: count=%0d first=%h second=%h, expected %h %h", res.size(),
                     res.size() > 0 ? res[0] : 64'h0, res.size() > 1 ? res[1] : 64'h0, R0, R1);
        end
        $display("back_to_back results=%0d", res.size());
        // settle back to IDLE with nothing pending
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [63:0] r;
        int lat;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_idle: in_ready=%b, expected 1", in_ready);
        end
        in_data = W1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b data=%h busy=%b, expected 1 0 0 0",
                     in_ready, out_valid, out_data, busy);
        end
        do_word(W0, 1'b0, r, lat);
        checks++;
        if (r !== R0 || lat !== 8) begin
            errors++;
            $display("FAIL reset_mid_next: got %h lat=%0d, expected %h lat=8", r, lat, R0);
        end
        $display("reset_mid then word %h -> %h", W0, r);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random(1'b0);
        test_random(1'b1);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
